// File: rtl/core_sequencer_if.sv
// core_sequencer_if: control bundle between the instruction sequencer and the
// datapath / memory side.
//   master : sequencer view (decoded IR fields and memory/fault status in,
//            check enables, write strobes, memory requests, mux selects out)
//   slave  : datapath / memory / debug view (the reverse directions)
interface core_sequencer_if;

  localparam int unsigned OPC_W = 7;
  localparam int unsigned F3_W  = 3;
  localparam int unsigned SEL_W = 2;

  // Decoded instruction fields and status from the datapath
  logic [OPC_W-1:0] opcode;
  logic [F3_W-1:0]  f3;
  logic             mem_complete_read;
  logic             mem_complete_write;
  logic             exception;
  logic             halt_req;

  // Check enables
  logic             check_mem;
  logic             check_inst;
  logic             check_ialign;
  logic             check_csr;

  // Register write strobes
  logic             write_pc;
  logic             write_ir;
  logic             write_rd;
  logic             write_csr;

  // Memory request and datapath selects
  logic             mem_read;
  logic             mem_write;
  logic             addr_sel;
  logic [SEL_W-1:0] rd_sel;
  logic [SEL_W-1:0] alu_insel1;
  logic [SEL_W-1:0] alu_insel2;

  // Status
  logic             trap_taken;
  logic             halted;

  modport master (
    input  opcode, f3, mem_complete_read, mem_complete_write, exception, halt_req,
    output check_mem, check_inst, check_ialign, check_csr,
           write_pc, write_ir, write_rd, write_csr,
           mem_read, mem_write, addr_sel, rd_sel, alu_insel1, alu_insel2,
           trap_taken, halted
  );

  modport slave (
    output opcode, f3, mem_complete_read, mem_complete_write, exception, halt_req,
    input  check_mem, check_inst, check_ialign, check_csr,
           write_pc, write_ir, write_rd, write_csr,
           mem_read, mem_write, addr_sel, rd_sel, alu_insel1, alu_insel2,
           trap_taken, halted
  );

endinterface

// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle RV32-style instruction sequencer.
// Walks FETCH -> DECODE -> EXEC [-> MEM_RD | MEM_WR] and retires either back
// to FETCH or into HALTED for debug. Outputs are decoded from the current
// state plus same-cycle inputs (memory completion, exception), so strobes
// line up with the cycle in which the event is seen.
// Ports:
//   clk   : core clock
//   rst_n : asynchronous active-low reset
//   bus   : core_sequencer_if.master (opcode/f3/status in, controls out)
module core_sequencer (
  input  logic             clk,
  input  logic             rst_n,
  core_sequencer_if.master bus
);

  localparam int unsigned SEL_W = 2;
  localparam int unsigned OPC_W = 7;
  localparam int unsigned F3_W  = 3;

  // Major opcodes
  localparam logic [OPC_W-1:0] OPC_OP       = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_LUI      = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_JAL      = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_JALR     = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_LOAD     = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE    = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [OPC_W-1:0] OPC_MISC_MEM = 7'b0001111;

  // f3 of ECALL/EBREAK; any other SYSTEM f3 is a CSR access
  localparam logic [F3_W-1:0] F3_PRIV = 3'b000;

  // Mux encodings
  localparam logic             ADDR_PC  = 1'b0;
  localparam logic             ADDR_ALU = 1'b1;
  localparam logic [SEL_W-1:0] RD_ALU   = 2'b00;
  localparam logic [SEL_W-1:0] RD_MEM   = 2'b01;
  localparam logic [SEL_W-1:0] RD_PC4   = 2'b10;
  localparam logic [SEL_W-1:0] RD_CSR   = 2'b11;
  localparam logic [SEL_W-1:0] IN1_RS1  = 2'b00;
  localparam logic [SEL_W-1:0] IN1_PC   = 2'b01;
  localparam logic [SEL_W-1:0] IN1_ZERO = 2'b10;
  localparam logic [SEL_W-1:0] IN2_RS2  = 2'b00;
  localparam logic [SEL_W-1:0] IN2_IMM  = 2'b01;

  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_DECODE  = 3'd1,
    ST_EXEC    = 3'd2,
    ST_MEM_RD  = 3'd3,
    ST_MEM_WR  = 3'd4,
    ST_HALTED  = 3'd5
  } state_e;

  typedef struct packed {
    logic             check_mem;
    logic             check_inst;
    logic             check_ialign;
    logic             check_csr;
    logic             write_pc;
    logic             write_ir;
    logic             write_rd;
    logic             write_csr;
    logic             mem_read;
    logic             mem_write;
    logic             addr_sel;
    logic [SEL_W-1:0] rd_sel;
    logic [SEL_W-1:0] alu_insel1;
    logic [SEL_W-1:0] alu_insel2;
    logic             trap_taken;
    logic             halted;
  } ctrl_t;

  state_e state_q, state_d;
  state_e retire_state_c;
  logic   active_q;
  logic   exc_c;
  logic   retire_c;
  ctrl_t  ctrl_c;

  // State register. active_q holds all outputs quiet until the first clock
  // after reset release, so no request is raised while reset is asserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_FETCH;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      active_q <= 1'b1;
    end
  end

  // Next-state and control decode
  always_comb begin
    ctrl_c         = '0;
    state_d        = state_q;
    retire_c       = 1'b0;
    exc_c          = bus.exception && (state_q != ST_HALTED);
    retire_state_c = bus.halt_req ? ST_HALTED : ST_FETCH;

    case (state_q)
      ST_FETCH: begin
        ctrl_c.mem_read  = 1'b1;
        ctrl_c.addr_sel  = ADDR_PC;
        ctrl_c.check_mem = 1'b1;
        if (bus.mem_complete_read && !exc_c) begin
          ctrl_c.write_ir = 1'b1;
          state_d         = ST_DECODE;
        end
      end

      ST_DECODE: begin
        ctrl_c.check_inst = 1'b1;
        state_d           = ST_EXEC;
      end

      ST_EXEC: begin
        // Everything except loads/stores finishes here
        retire_c = 1'b1;
        case (bus.opcode)
          OPC_OP: begin
            ctrl_c.alu_insel1 = IN1_RS1;
            ctrl_c.alu_insel2 = IN2_RS2;
            ctrl_c.rd_sel     = RD_ALU;
            ctrl_c.write_rd   = 1'b1;
            ctrl_c.write_pc   = 1'b1;
          end
          OPC_OP_IMM: begin
            ctrl_c.alu_insel2 = IN2_IMM;
            ctrl_c.write_rd   = 1'b1;
            ctrl_c.write_pc   = 1'b1;
          end
          OPC_LUI: begin
            ctrl_c.alu_insel1 = IN1_ZERO;
            ctrl_c.alu_insel2 = IN2_IMM;
            ctrl_c.write_rd   = 1'b1;
            ctrl_c.write_pc   = 1'b1;
          end
          OPC_AUIPC: begin
            ctrl_c.alu_insel1 = IN1_PC;
            ctrl_c.alu_insel2 = IN2_IMM;
            ctrl_c.write_rd   = 1'b1;
            ctrl_c.write_pc   = 1'b1;
          end
          OPC_JAL: begin
            ctrl_c.alu_insel1   = IN1_PC;
            ctrl_c.alu_insel2   = IN2_IMM;
            ctrl_c.rd_sel       = RD_PC4;
            ctrl_c.write_rd     = 1'b1;
            ctrl_c.write_pc     = 1'b1;
            ctrl_c.check_ialign = 1'b1;
          end
          OPC_JALR: begin
            ctrl_c.alu_insel2   = IN2_IMM;
            ctrl_c.rd_sel       = RD_PC4;
            ctrl_c.write_rd     = 1'b1;
            ctrl_c.write_pc     = 1'b1;
            ctrl_c.check_ialign = 1'b1;
          end
          OPC_BRANCH: begin
            ctrl_c.write_pc     = 1'b1;
            ctrl_c.check_ialign = 1'b1;
          end
          OPC_LOAD: begin
            ctrl_c.alu_insel2 = IN2_IMM;
            retire_c          = 1'b0;
            state_d           = ST_MEM_RD;
          end
          OPC_STORE: begin
            ctrl_c.alu_insel2 = IN2_IMM;
            retire_c          = 1'b0;
            state_d           = ST_MEM_WR;
          end
          OPC_SYSTEM: begin
            ctrl_c.write_pc = 1'b1;
            if (bus.f3 != F3_PRIV) begin
              ctrl_c.check_csr = 1'b1;
              ctrl_c.write_csr = 1'b1;
              ctrl_c.rd_sel    = RD_CSR;
              ctrl_c.write_rd  = 1'b1;
            end
          end
          OPC_MISC_MEM: begin
            ctrl_c.write_pc = 1'b1;
          end
          default: ;
        endcase
      end

      ST_MEM_RD: begin
        // Address selects stay valid for the whole access
        ctrl_c.mem_read   = 1'b1;
        ctrl_c.addr_sel   = ADDR_ALU;
        ctrl_c.check_mem  = 1'b1;
        ctrl_c.alu_insel1 = IN1_RS1;
        ctrl_c.alu_insel2 = IN2_IMM;
        if (bus.mem_complete_read && !exc_c) begin
          ctrl_c.rd_sel   = RD_MEM;
          ctrl_c.write_rd = 1'b1;
          ctrl_c.write_pc = 1'b1;
          retire_c        = 1'b1;
        end
      end

      ST_MEM_WR: begin
        ctrl_c.mem_write  = 1'b1;
        ctrl_c.addr_sel   = ADDR_ALU;
        ctrl_c.check_mem  = 1'b1;
        ctrl_c.alu_insel1 = IN1_RS1;
        ctrl_c.alu_insel2 = IN2_IMM;
        if (bus.mem_complete_write && !exc_c) begin
          ctrl_c.write_pc = 1'b1;
          retire_c        = 1'b1;
        end
      end

      ST_HALTED: begin
        ctrl_c.halted = 1'b1;
        if (!bus.halt_req) begin
          state_d = ST_FETCH;
        end
      end

      default: begin
        state_d = ST_FETCH;
      end
    endcase

    // A fault aborts the instruction: suppress all register writes and retire
    if (exc_c) begin
      ctrl_c.write_pc   = 1'b0;
      ctrl_c.write_ir   = 1'b0;
      ctrl_c.write_rd   = 1'b0;
      ctrl_c.write_csr  = 1'b0;
      ctrl_c.trap_taken = 1'b1;
      retire_c          = 1'b1;
    end

    if (retire_c) begin
      state_d = retire_state_c;
    end

    // Quiet cycle straight out of reset: no requests, no state movement
    if (!active_q) begin
      ctrl_c  = '0;
      state_d = state_q;
    end
  end

  assign bus.check_mem    = ctrl_c.check_mem;
  assign bus.check_inst   = ctrl_c.check_inst;
  assign bus.check_ialign = ctrl_c.check_ialign;
  assign bus.check_csr    = ctrl_c.check_csr;
  assign bus.write_pc     = ctrl_c.write_pc;
  assign bus.write_ir     = ctrl_c.write_ir;
  assign bus.write_rd     = ctrl_c.write_rd;
  assign bus.write_csr    = ctrl_c.write_csr;
  assign bus.mem_read     = ctrl_c.mem_read;
  assign bus.mem_write    = ctrl_c.mem_write;
  assign bus.addr_sel     = ctrl_c.addr_sel;
  assign bus.rd_sel       = ctrl_c.rd_sel;
  assign bus.alu_insel1   = ctrl_c.alu_insel1;
  assign bus.alu_insel2   = ctrl_c.alu_insel2;
  assign bus.trap_taken   = ctrl_c.trap_taken;
  assign bus.halted       = ctrl_c.halted;

endmodule

// File: tb/tb_core_sequencer.sv
// tb_core_sequencer: directed scenarios plus randomized instruction streams.
// The random reference builds each instruction as a plan (opcode, wait
// counts, fault position, halt) and expands it into the expected per-cycle
// control vector.
module tb_core_sequencer;

  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

  // Instruction phases of the reference plan
  localparam int P_FETCH  = 0;
  localparam int P_DECODE = 1;
  localparam int P_EXEC   = 2;
  localparam int P_MEMRD  = 3;
  localparam int P_MEMWR  = 4;
  localparam int P_HALT   = 5;

  typedef struct packed {
    logic       check_mem;
    logic       check_inst;
    logic       check_ialign;
    logic       check_csr;
    logic       write_pc;
    logic       write_ir;
    logic       write_rd;
    logic       write_csr;
    logic       mem_read;
    logic       mem_write;
    logic       addr_sel;
    logic [1:0] rd_sel;
    logic [1:0] alu_insel1;
    logic [1:0] alu_insel2;
    logic       trap_taken;
    logic       halted;
  } ctl_t;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  ctl_t obs_c;

  core_sequencer_if sif ();

  core_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    obs_c              = '0;
    obs_c.check_mem    = sif.check_mem;
    obs_c.check_inst   = sif.check_inst;
    obs_c.check_ialign = sif.check_ialign;
    obs_c.check_csr    = sif.check_csr;
    obs_c.write_pc     = sif.write_pc;
    obs_c.write_ir     = sif.write_ir;
    obs_c.write_rd     = sif.write_rd;
    obs_c.write_csr    = sif.write_csr;
    obs_c.mem_read     = sif.mem_read;
    obs_c.mem_write    = sif.mem_write;
    obs_c.addr_sel     = sif.addr_sel;
    obs_c.rd_sel       = sif.rd_sel;
    obs_c.alu_insel1   = sif.alu_insel1;
    obs_c.alu_insel2   = sif.alu_insel2;
    obs_c.trap_taken   = sif.trap_taken;
    obs_c.halted       = sif.halted;
  end

  // Expected control vector for one cycle of a given phase
  function automatic ctl_t exp_phase(input int ph, input logic [6:0] opc,
                                     input logic [2:0] f3v, input bit done);
    ctl_t e;
    e = '0;
    case (ph)
      P_FETCH: begin
        e.mem_read  = 1'b1;
        e.check_mem = 1'b1;
        e.write_ir  = done;
      end
      P_DECODE: e.check_inst = 1'b1;
      P_EXEC: begin
        if (opc == OPC_OP) begin
          e.write_rd = 1'b1; e.write_pc = 1'b1;
        end else if (opc == OPC_OP_IMM) begin
          e.alu_insel2 = 2'b01; e.write_rd = 1'b1; e.write_pc = 1'b1;
        end else if (opc == OPC_LUI) begin
          e.alu_insel1 = 2'b10; e.alu_insel2 = 2'b01; e.write_rd = 1'b1; e.write_pc = 1'b1;
        end else if (opc == OPC_AUIPC) begin
          e.alu_insel1 = 2'b01; e.alu_insel2 = 2'b01; e.write_rd = 1'b1; e.write_pc = 1'b1;
        end else if (opc == OPC_JAL || opc == OPC_JALR) begin
          e.alu_insel1   = (opc == OPC_JAL) ? 2'b01 : 2'b00;
          e.alu_insel2   = 2'b01;
          e.rd_sel       = 2'b10;
          e.write_rd     = 1'b1;
          e.write_pc     = 1'b1;
          e.check_ialign = 1'b1;
        end else if (opc == OPC_BRANCH) begin
          e.write_pc = 1'b1; e.check_ialign = 1'b1;
        end else if (opc == OPC_LOAD || opc == OPC_STORE) begin
          e.alu_insel2 = 2'b01;
        end else if (opc == OPC_SYSTEM && f3v != 3'b000) begin
          e.check_csr = 1'b1; e.write_csr = 1'b1; e.rd_sel = 2'b11;
          e.write_rd  = 1'b1; e.write_pc  = 1'b1;
        end else if (opc == OPC_SYSTEM || opc == OPC_MISC_MEM) begin
          e.write_pc = 1'b1;
        end
      end
      P_MEMRD: begin
        e.mem_read = 1'b1; e.addr_sel = 1'b1; e.check_mem = 1'b1; e.alu_insel2 = 2'b01;
        if (done) begin
          e.rd_sel = 2'b01; e.write_rd = 1'b1; e.write_pc = 1'b1;
        end
      end
      P_MEMWR: begin
        e.mem_write = 1'b1; e.addr_sel = 1'b1; e.check_mem = 1'b1; e.alu_insel2 = 2'b01;
        e.write_pc  = done;
      end
      P_HALT: e.halted = 1'b1;
      default: ;
    endcase
    return e;
  endfunction

  // Fault in the cycle: register writes suppressed, trap pulse raised
  function automatic ctl_t with_trap(input ctl_t e);
    ctl_t r;
    r            = e;
    r.write_pc   = 1'b0;
    r.write_ir   = 1'b0;
    r.write_rd   = 1'b0;
    r.write_csr  = 1'b0;
    r.trap_taken = 1'b1;
    return r;
  endfunction

  function automatic logic [6:0] pick_opcode();
    case ($urandom_range(0, 11))
      0:       return OPC_OP;
      1:       return OPC_OP_IMM;
      2:       return OPC_LUI;
      3:       return OPC_AUIPC;
      4:       return OPC_JAL;
      5:       return OPC_JALR;
      6:       return OPC_BRANCH;
      7:       return OPC_LOAD;
      8:       return OPC_STORE;
      9:       return OPC_SYSTEM;
      10:      return OPC_MISC_MEM;
      default: return 7'b0101111;
    endcase
  endfunction

  // Apply one cycle of inputs at the falling edge and sample just after
  task automatic drive_cycle(input logic [6:0] opc, input logic [2:0] f3v,
                             input logic mcr, input logic mcw, input logic exc,
                             input logic hreq, output ctl_t obs);
    @(negedge clk);
    sif.opcode             = opc;
    sif.f3                 = f3v;
    sif.mem_complete_read  = mcr;
    sif.mem_complete_write = mcw;
    sif.exception          = exc;
    sif.halt_req           = hreq;
    #1;
    obs = obs_c;
  endtask

  task automatic test_reset();
    ctl_t obs, exp;
    drive_cycle(OPC_OP, 3'b001, 1'b1, 1'b1, 1'b1, 1'b1, obs);
    exp = '0;
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL reset_quiet obs=%h exp=%h", obs, exp);
    end
    drive_cycle(7'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, obs);
    rst_n = 1'b1;
    drive_cycle(7'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, obs);
    exp = exp_phase(P_FETCH, 7'd0, 3'd0, 1'b0);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL reset_fetch obs=%h exp=%h", obs, exp);
    end
  endtask

  task automatic test_add();
    ctl_t obs, exp;
    drive_cycle(OPC_OP, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, obs);
    exp = exp_phase(P_FETCH, OPC_OP, 3'd0, 1'b1);
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL add_fetch obs=%h exp=%h", obs, exp); end
    drive_cycle(OPC_OP, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, obs);
    exp = exp_phase(P_DECODE, OPC_OP, 3'd0, 1'b0);
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL add_decode obs=%h exp=%h", obs, exp); end
    drive_cycle(OPC_OP, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, obs);
    exp = exp_phase(P_EXEC, OPC_OP, 3'd0, 1'b0);
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL add_exec obs=%h exp=%h", obs, exp); end
    drive_cycle(OPC_OP, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, obs);
    exp = exp_phase(P_FETCH, OPC_OP, 3'd0, 1'b0);
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL add_next_fetch obs=%h exp=%h", obs, exp); end
  endtask

  task automatic test_load_wait();
    ctl_t obs, exp;
    drive_cycle(OPC_LOAD, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0, obs);
    drive_cycle(OPC_LOAD, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, obs);
    drive_cycle(OPC_LOAD, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0, obs);
    exp = exp_phase(P_EXEC, OPC_LOAD, 3'b010, 1'b0);
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL lw_exec obs=%h exp=%h", obs, exp); end
    for (int k = 0; k < 3; k++) begin
      drive_cycle(OPC_LOAD, 3'b010, (k == 2), 1'b1, 1'b0, 1'b0, obs);
      exp = exp_phase(P_MEMRD, OPC_LOAD, 3'b010, (k == 2));
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL lw_memrd_%0d obs=%h exp=%h", k, obs, exp);
      end
    end
    drive_cycle(OPC_LOAD, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, obs);
    exp = exp_phase(P_FETCH, OPC_LOAD, 3'b010, 1'b0);
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL lw_next_fetch obs=%h exp=%h", obs, exp); end
  endtask

  task automatic test_store_exception();
    ctl_t obs, exp;
    drive_cycle(OPC_STORE, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0, obs);
    drive_cycle(OPC_STORE, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, obs);
    drive_cycle(OPC_STORE, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, obs);
    drive_cycle(OPC_STORE, 3'b010, 1'b0, 1'b1, 1'b1, 1'b0, obs);
    exp = with_trap(exp_phase(P_MEMWR, OPC_STORE, 3'b010, 1'b0));
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL sw_exception obs=%h exp=%h", obs, exp); end
    drive_cycle(OPC_STORE, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, obs);
    exp = exp_phase(P_FETCH, OPC_STORE, 3'b010, 1'b0);
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL sw_trap_fetch obs=%h exp=%h", obs, exp); end
  endtask

  task automatic test_jal_halt();
    ctl_t obs, exp;
    drive_cycle(OPC_JAL, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, obs);
    drive_cycle(OPC_JAL, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, obs);
    drive_cycle(OPC_JAL, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, obs);
    exp = exp_phase(P_EXEC, OPC_JAL, 3'd0, 1'b0);
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL jal_exec obs=%h exp=%h", obs, exp); end
    drive_cycle(OPC_JAL, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1, obs);
    exp = exp_phase(P_HALT, OPC_JAL, 3'd0, 1'b0);
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL jal_halted obs=%h exp=%h", obs, exp); end
    drive_cycle(OPC_JAL, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, obs);
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL jal_halt_release obs=%h exp=%h", obs, exp); end
    drive_cycle(OPC_JAL, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, obs);
    exp = exp_phase(P_FETCH, OPC_JAL, 3'd0, 1'b0);
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL jal_resume_fetch obs=%h exp=%h", obs, exp); end
  endtask

  task automatic test_system();
    ctl_t obs, exp;
    logic [2:0] f3s [2];
    f3s[0] = 3'b001;
    f3s[1] = 3'b000;
    for (int k = 0; k < 2; k++) begin
      drive_cycle(OPC_SYSTEM, f3s[k], 1'b1, 1'b0, 1'b0, 1'b0, obs);
      drive_cycle(OPC_SYSTEM, f3s[k], 1'b0, 1'b0, 1'b0, 1'b0, obs);
      drive_cycle(OPC_SYSTEM, f3s[k], 1'b0, 1'b0, 1'b0, 1'b0, obs);
      exp = exp_phase(P_EXEC, OPC_SYSTEM, f3s[k], 1'b0);
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL system_f3_%0d obs=%h exp=%h", f3s[k], obs, exp);
      end
    end
  endtask

  task automatic test_reset_mid_store();
    ctl_t obs, exp;
    drive_cycle(OPC_STORE, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, obs);
    drive_cycle(OPC_STORE, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, obs);
    drive_cycle(OPC_STORE, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, obs);
    drive_cycle(OPC_STORE, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, obs);
    exp = exp_phase(P_MEMWR, OPC_STORE, 3'd0, 1'b0);
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL mid_memwr obs=%h exp=%h", obs, exp); end
    #1;
    rst_n = 1'b0;
    #1;
    obs = obs_c;
    exp = '0;
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL mid_reset_drop obs=%h exp=%h", obs, exp); end
    drive_cycle(OPC_STORE, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, obs);
    rst_n = 1'b1;
    drive_cycle(OPC_STORE, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, obs);
    exp = exp_phase(P_FETCH, OPC_STORE, 3'd0, 1'b0);
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL mid_reset_fetch obs=%h exp=%h", obs, exp); end
  endtask

  task automatic test_random(input int n_instr);
    ctl_t       obs, exp;
    logic [6:0] opc;
    logic [2:0] f3v;
    int         wf, wm, len, exc_at, ph, hold;
    bit         h, is_ld, is_st, done, exc, retire;
    logic       mcr, mcw, hreq;
    for (int i = 0; i < n_instr; i++) begin
      opc    = pick_opcode();
      f3v    = 3'($urandom_range(0, 7));
      is_ld  = (opc == OPC_LOAD);
      is_st  = (opc == OPC_STORE);
      wf     = int'($urandom_range(0, 2));
      wm     = int'($urandom_range(0, 2));
      len    = wf + 3 + ((is_ld || is_st) ? (wm + 1) : 0);
      exc_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len - 1)) : -1;
      h      = ($urandom_range(0, 3) == 0);
      for (int c = 0; c < len; c++) begin
        done = 1'b0;
        if (c <= wf) begin
          ph = P_FETCH; done = (c == wf);
        end else if (c == wf + 1) begin
          ph = P_DECODE;
        end else if (c == wf + 2) begin
          ph = P_EXEC;
        end else begin
          ph = is_ld ? P_MEMRD : P_MEMWR; done = (c == len - 1);
        end
        exc    = (c == exc_at);
        retire = exc || (c == len - 1);
        mcr    = (ph == P_FETCH || ph == P_MEMRD) ? done : 1'($urandom_range(0, 1));
        mcw    = (ph == P_MEMWR) ? done : 1'($urandom_range(0, 1));
        if (exc) begin
          mcr = 1'($urandom_range(0, 1));
          mcw = 1'($urandom_range(0, 1));
        end
        hreq = retire ? h : 1'($urandom_range(0, 1));
        drive_cycle((ph == P_FETCH) ? 7'($urandom_range(0, 127)) : opc, f3v,
                    mcr, mcw, exc, hreq, obs);
        exp = exp_phase(ph, opc, f3v, done && !exc);
        if (exc) exp = with_trap(exp);
        vectors++;
        if (obs !== exp) begin
          miscompares++;
          $display("FAIL rand_instr i=%0d opc=%b f3=%0d cyc=%0d obs=%h exp=%h",
                   i, opc, f3v, c, obs, exp);
        end
        if (exc) break;
      end
      if (h) begin
        hold = int'($urandom_range(0, 2));
        for (int k = 0; k <= hold; k++) begin
          drive_cycle(7'($urandom_range(0, 127)), 3'($urandom_range(0, 7)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), (k < hold), obs);
          exp = exp_phase(P_HALT, opc, f3v, 1'b0);
          vectors++;
          if (obs !== exp) begin
            miscompares++;
            $display("FAIL rand_halt i=%0d k=%0d obs=%h exp=%h", i, k, obs, exp);
          end
        end
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

  initial begin
    vectors                = 0;
    miscompares            = 0;
    rst_n                  = 1'b0;
    sif.opcode             = '0;
    sif.f3                 = '0;
    sif.mem_complete_read  = 1'b0;
    sif.mem_complete_write = 1'b0;
    sif.exception          = 1'b0;
    sif.halt_req           = 1'b0;
    test_reset();
    test_add();
    test_load_wait();
    test_store_exception();
    test_jal_halt();
    test_system();
    test_reset_mid_store();
    test_random(400);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/core_sequencer.md
CORE_SEQUENCER -- requirements
Module: core_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; all state changes on the rising edge of clk; rst_n low forces reset state immediately.
REQ-002 The block SHALL have these ports:
- clk  in  1  core clock
- rst_n  in  1  async active-low reset
- opcode  in  7  IR[6:0]
- f3  in  3  IR[14:12]
- mem_complete_read  in  1  read data valid this cycle
- mem_complete_write  in  1  write accepted this cycle
- exception  in  1  fault flagged by datapath check logic this cycle
- halt_req  in  1  debug halt request, level
- check_mem, check_inst, check_ialign, check_csr  out  1 each  enable datapath checks
- write_pc, write_ir, write_rd, write_csr  out  1 each  register write strobes
- mem_read, mem_write  out  1 each  memory request, level-held until complete
- addr_sel  out  1  memory address: 0 = PC, 1 = ALU result
- rd_sel  out  2  rd source: 00 ALU, 01 memory, 10 PC+4, 11 CSR
- alu_insel1  out  2  00 rs1, 01 PC, 10 zero
- alu_insel2  out  2  00 rs2, 01 imm, 10 constant 4
- trap_taken  out  1  one-cycle pulse: instruction aborted
- halted  out  1  core parked for debug

Function
REQ-003 States SHALL be FETCH, DECODE, EXEC, MEM_RD, MEM_WR, HALTED; outputs not listed for a state are 0.
REQ-004 FETCH: mem_read=1, addr_sel=0, check_mem=1; remains until mem_complete_read; in that cycle write_ir=1 and next state is DECODE.
REQ-005 DECODE: check_inst=1; always advances to EXEC after one cycle.
REQ-006 EXEC, OP (0110011): insel1=00, insel2=00, rd_sel=00, write_rd=1, write_pc=1; retire.
REQ-007 EXEC, OP-IMM (0010011): insel1=00, insel2=01, rd_sel=00, write_rd=1, write_pc=1; retire.
REQ-008 EXEC, LUI (0110111): insel1=10, insel2=01; AUIPC (0010111): insel1=01, insel2=01; both rd_sel=00, write_rd=1, write_pc=1; retire.
REQ-009 EXEC, JAL (1101111): insel1=01, insel2=01; JALR (1100111): insel1=00, insel2=01; both rd_sel=10, write_rd=1, write_pc=1, check_ialign=1; retire.
REQ-010 EXEC, BRANCH (1100011): insel1=00, insel2=00, write_pc=1, check_ialign=1; retire.
REQ-011 EXEC, LOAD (0000011): insel1=00, insel2=01; next MEM_RD. STORE (0100011): same selects; next MEM_WR.
REQ-012 EXEC, SYSTEM (1110011) with f3!=000: check_csr=1, write_csr=1, rd_sel=11, write_rd=1, write_pc=1. With f3==000, and for MISC-MEM (0001111): write_pc=1 only. Retire in both cases.
REQ-013 EXEC, any other opcode: no strobes; retire.
REQ-014 MEM_RD: mem_read=1, addr_sel=1, check_mem=1, insel1=00, insel2=01 held; on mem_complete_read: rd_sel=01, write_rd=1, write_pc=1; retire.
REQ-015 MEM_WR: mem_write=1, addr_sel=1, check_mem=1, selects held; on mem_complete_write: write_pc=1; retire.
REQ-016 Retire SHALL go to HALTED if halt_req=1 in the retire cycle, else to FETCH.
REQ-017 HALTED: halted=1, no memory request; exits to FETCH in the cycle after halt_req is sampled 0.
REQ-018 exception=1 in FETCH, DECODE, EXEC, MEM_RD or MEM_WR SHALL combinationally force write_pc, write_ir, write_rd and write_csr to 0 in that cycle, assert trap_taken=1, and take the retire transition (REQ-016). Exception has priority over mem_complete_* in the same cycle.
REQ-019 exception SHALL be ignored in HALTED.
REQ-020 Latency with single-cycle memory: ALU, jump, branch and CSR instructions take 3 cycles; loads and stores take 4 cycles. Wait cycles add 1:1.
REQ-021 mem_complete_* arriving in a state that does not request that access SHALL be ignored.

Reset
REQ-022 While rst_n=0, the state SHALL be FETCH and trap_taken=0 and halted=0. FETCH outputs (mem_read=1, addr_sel=0, check_mem=1) apply from the first clock after release.
REQ-023 Reset asserted mid-instruction SHALL abandon that instruction with no further strobes.

Verification
REQ-024 ADD (0110011), single-cycle memory -> write_ir in cycle 1, DECODE in cycle 2, write_rd=1, write_pc=1, rd_sel=00 in cycle 3, then FETCH.
REQ-025 LW with mem_complete_read delayed 2 cycles in MEM_RD -> mem_read/addr_sel=1 held 3 cycles; write_rd with rd_sel=01 only in the completion cycle.
REQ-026 SW with exception=1 and mem_complete_write=1 in the same cycle -> no write_pc, trap_taken=1, next state FETCH.
REQ-027 halt_req=1 during a JAL retire -> halted=1 from the next cycle; halt_req dropped -> FETCH one cycle later, with mem_read=1.
REQ-028 CSRRW (1110011, f3=001) -> check_csr, write_csr, write_rd=1, rd_sel=11. ECALL (f3=000) -> write_pc only.
REQ-029 rst_n pulsed low during MEM_WR -> mem_write drops immediately; FETCH follows after release.
